shared_addsub_rr: RTL

- Time-shared add/subtract unit. `CH` independent operand channels compete for one `WIDTH`-bit adder.
- A round-robin arbiter picks one requesting channel per cycle and computes `a+b` or `a−b` for it.
- The result is registered with its channel tag, carry, and signed-overflow flag, and is held behind a valid/ready output handshake.
- It sits where several datapath clients need occasional arithmetic and a dedicated adder per client is not justified.

---
 rtl/shared_addsub_rr.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shared_addsub_rr.sv
// Time-shared WIDTH-bit add/subtract unit serving CH channels through a
// round-robin arbiter, with a registered valid/ready result port.
module shared_addsub_rr #(
  parameter  int WIDTH = 8,
  parameter  int CH    = 4,
  localparam int CHW   = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic [CH*WIDTH-1:0]   in_a,
  input  logic [CH*WIDTH-1:0]   in_b,
  input  logic [CH-1:0]         in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH:0]        out_sum,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_ovf
);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [WIDTH:0] out_sum_q, out_sum_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic           out_ovf_q, out_ovf_d;

  logic           found;
  logic [CHW-1:0] grant_idx;
  logic [CH-1:0]  grant;
  logic           can_accept;
  logic           transfer;

  logic [WIDTH-1:0] a_sel, b_sel, b_eff;
  logic             sub_sel;
  logic [WIDTH:0]   sum_c;
  logic             ovf_c;

  // Search order starts at ptr and wraps; the first requester wins.
  always_comb begin
    int unsigned    idx;
    logic [CHW-1:0] sel;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= CH) idx = idx - CH;
      sel = CHW'(idx);
      if (!found && in_valid[sel]) begin
        found     = 1'b1;
        grant_idx = sel;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      grant[k] = found && (grant_idx == CHW'(k));
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign transfer   = found && can_accept;
  assign in_ready   = (rst_n && can_accept) ? grant : '0;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (grant_idx == CHW'(k)) begin
        a_sel   = in_a[k*WIDTH +: WIDTH];
        b_sel   = in_b[k*WIDTH +: WIDTH];
        sub_sel = in_sub[k];
      end
    end
  end

  // Subtract is a + ~b + 1, so the carry out reads as not-borrow.
  always_comb begin
    b_eff = sub_sel ? ~b_sel : b_sel;
    sum_c = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    ovf_c = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) && (sum_c[WIDTH-1] != a_sel[WIDTH-1]);
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ch_d    = out_ch_q;
    out_ovf_d   = out_ovf_q;
    if (transfer) begin
      ptr_d       = (grant_idx == CHW'(CH - 1)) ? '0 : grant_idx + CHW'(1);
      out_valid_d = 1'b1;
      out_sum_d   = sum_c;
      out_ch_d    = grant_idx;
      out_ovf_d   = ovf_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule
